// File: rtl/div_ratio_meter_if.sv
// Meter-side bundle: enable and strobe under measurement in; period, duty and status out.
// The meter takes the slave view; whoever consumes the measurement holds the master view.
interface div_ratio_meter_if #(
    parameter int unsigned WIDTH = 32
);
    logic             en;
    logic             in_clk;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] high_time;
    logic             valid;
    logic             locked;
    logic             timeout;

    modport master (
        output en, in_clk,
        input  period, high_time, valid, locked, timeout
    );

    modport slave (
        input  en, in_clk,
        output period, high_time, valid, locked, timeout
    );
endinterface

// File: rtl/div_ratio_meter.sv
// Period/duty meter for a slow strobe with lock and no-edge timeout; DIV_RATIO_METER_DUTY_EN builds high_time.
// Latency: valid SYNC_STAGES+1 clk after the sampled in_clk rise; no backpressure, valid is a one-cycle pulse.
module div_ratio_meter #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned LOCK_CNT    = 4,
    parameter int unsigned TIMEOUT     = 1000000
) (
    input  logic              clk,
    input  logic              rst,
    div_ratio_meter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARM, MEAS} state_t;

    localparam logic [WIDTH-1:0] TIMEOUT_W = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
    localparam logic [3:0]       MATCH_MAX = 4'(LOCK_CNT - 1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_d_q, s_d_d;
    logic [WIDTH-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       period_q, period_d;
    logic                   valid_q, valid_d;
    logic                   locked_q, locked_d;
    logic                   timeout_q, timeout_d;
    logic [3:0]             match_q, match_d;
    logic                   first_q, first_d;
    logic                   s;
    logic                   rise;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.in_clk};
        s_d_d  = s;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        period_d  = period_q;
        valid_d   = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        match_d   = match_q;
        first_d   = first_q;
        if (!bus.en) begin
            state_d   = IDLE;
            cnt_d     = '0;
            match_d   = '0;
            locked_d  = 1'b0;
            timeout_d = 1'b0;
            first_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = ARM;
                end
                ARM: begin
                    if (rise) begin
                        cnt_d   = ONE_W;
                        first_d = 1'b1;
                        state_d = MEAS;
                    end
                end
                MEAS: begin
                    // A rise landing on the timeout count is a valid measurement, not a loss.
                    if (rise) begin
                        period_d  = cnt_q;
                        valid_d   = 1'b1;
                        cnt_d     = ONE_W;
                        timeout_d = 1'b0;
                        first_d   = 1'b0;
                        if (first_q || (cnt_q != period_q)) begin
                            match_d = '0;
                        end else if (match_q != MATCH_MAX) begin
                            match_d = match_q + 4'd1;
                        end
                        locked_d = (match_d == MATCH_MAX);
                    end else if (cnt_q == TIMEOUT_W) begin
                        timeout_d = 1'b1;
                        locked_d  = 1'b0;
                        match_d   = '0;
                        cnt_d     = '0;
                        state_d   = ARM;
                    end else begin
                        cnt_d = cnt_q + ONE_W;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sync_q    <= '0;
            s_d_q     <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
            match_q   <= '0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            s_d_q     <= s_d_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
            match_q   <= match_d;
            first_q   <= first_d;
        end
    end

`ifdef DIV_RATIO_METER_DUTY_EN
    logic [WIDTH-1:0] hcnt_q, hcnt_d;
    logic [WIDTH-1:0] high_time_q, high_time_d;

    always_comb begin
        hcnt_d      = hcnt_q;
        high_time_d = high_time_q;
        if (!bus.en || (state_q == IDLE)) begin
            hcnt_d = '0;
        end else if (rise) begin
            hcnt_d = ONE_W;
            if (state_q == MEAS) begin
                high_time_d = hcnt_q;
            end
        end else if (state_q == MEAS) begin
            hcnt_d = (cnt_q == TIMEOUT_W) ? '0 : hcnt_q + WIDTH'(s);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q      <= '0;
            high_time_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            high_time_q <= high_time_d;
        end
    end

    assign bus.high_time = high_time_q;
`else
    assign bus.high_time = '0;
`endif

    assign bus.period  = period_q;
    assign bus.valid   = valid_q;
    assign bus.locked  = locked_q;
    assign bus.timeout = timeout_q;

endmodule

// File: tb/tb_div_ratio_meter.sv
// Directed + randomized bench for div_ratio_meter; expectations come from the driven rise times and segment lengths.
module tb_div_ratio_meter;
    localparam int WIDTH = 16;
    localparam int SYNC  = 2;
    localparam int LOCK  = 4;
    localparam int TMO   = 100;
`ifdef DIV_RATIO_METER_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    typedef struct {
        int   c;
        int   p;
        int   h;
        logic lk;
        logic to;
    } vrec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    vrec_t vlog[$];
    int    seg_rise[$];
    int    seg_h[$];
    int    pers[$];
    int    to_set_cyc = -1;
    int    to_clr_cyc = -1;
    logic  to_prev = 1'b0;

    div_ratio_meter_if #(.WIDTH(WIDTH)) bus();

    div_ratio_meter #(
        .WIDTH(WIDTH), .SYNC_STAGES(SYNC), .LOCK_CNT(LOCK), .TIMEOUT(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid === 1'b1)
            vlog.push_back('{cyc, int'(bus.period), int'(bus.high_time), bus.locked, bus.timeout});
        if (bus.timeout === 1'b1 && to_prev !== 1'b1) to_set_cyc = cyc;
        if (bus.timeout === 1'b0 && to_prev === 1'b1) to_clr_cyc = cyc;
        to_prev = bus.timeout;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.in_clk = 1'b0;
        end
    endtask

    // One waveform period: rises, stays high h cycles, low l cycles.
    task automatic drive_seg(input int h, input int l);
        for (int i = 0; i < h + l; i++) begin
            @(negedge clk);
            if (i == 0) begin
                seg_rise.push_back(cyc);
                seg_h.push_back(h);
            end
            bus.in_clk = (i < h);
        end
    endtask

    task automatic start_run();
        @(negedge clk);
        bus.en = 1'b1;
        bus.in_clk = 1'b0;
        seg_rise.delete();
        seg_h.delete();
        pers.delete();
        vlog.delete();
        idle(3);
    endtask

    function automatic logic exp_lock(input int i);
        if (i + 1 < LOCK) return 1'b0;
        for (int k = i - LOCK + 1; k < i; k++)
            if (pers[k] != pers[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Every rise after the first in a run yields one valid: period = gap between rises, high = preceding high length.
    task automatic check_run(input string name);
        int nexp;
        int n;
        nexp = seg_rise.size() - 1;
        chk({name, ".vcount"}, vlog.size(), nexp);
        n = (vlog.size() < nexp) ? vlog.size() : nexp;
        for (int i = 0; i < nexp; i++) pers.push_back(seg_rise[i+1] - seg_rise[i]);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s.v%0d.period", name, i), vlog[i].p, pers[i]);
            chk($sformatf("%s.v%0d.high", name, i), vlog[i].h, DUTY ? seg_h[i] : 0);
            chk($sformatf("%s.v%0d.cyc", name, i), vlog[i].c, seg_rise[i+1] + SYNC + 1);
            chk($sformatf("%s.v%0d.locked", name, i), vlog[i].lk, exp_lock(i));
            chk($sformatf("%s.v%0d.timeout", name, i), vlog[i].to, 1'b0);
        end
    endtask

    task automatic end_run(input string name);
        idle(4);
        check_run(name);
        @(negedge clk);
        bus.en = 1'b0;
        idle(2);
    endtask

    initial begin
        int last_rise;
        int nv;
        int bh, bl, nseg, h, l;
        bus.en = 1'b0;
        bus.in_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.period", bus.period, 0);
        chk("rst.high", bus.high_time, 0);
        chk("rst.valid", bus.valid, 0);
        chk("rst.locked", bus.locked, 0);
        chk("rst.timeout", bus.timeout, 0);
        rst = 1'b0;

        // clk/4 to lock, then clk/6: lock drops and re-forms; then en low holds period
        start_run();
        repeat (8) drive_seg(2, 2);
        repeat (5) drive_seg(3, 3);
        idle(4);
        check_run("div4to6");
        @(negedge clk);
        bus.en = 1'b0;
        nv = vlog.size();
        idle(4);
        chk("en_off.locked", bus.locked, 0);
        chk("en_off.period", bus.period, 6);
        chk("en_off.high", bus.high_time, DUTY ? 3 : 0);
        chk("en_off.novalid", vlog.size(), nv);

        start_run();
        repeat (6) drive_seg(1, 1);
        end_run("div2");
        start_run();
        repeat (5) drive_seg(3, 2);
        end_run("odd32");

        // Loss of signal after a locked clk/4 run
        start_run();
        repeat (5) drive_seg(2, 2);
        to_set_cyc = -1;
        last_rise = seg_rise[seg_rise.size()-1];
        for (int i = 0; i < 200 && to_set_cyc < 0; i++) idle(1);
        check_run("pre_to");
        chk("to.cycle", to_set_cyc, last_rise + SYNC + 1 + TMO);
        chk("to.flag", bus.timeout, 1);
        chk("to.locked", bus.locked, 0);
        chk("to.period", bus.period, 4);
        to_clr_cyc = -1;
        start_run();
        chk("to.sticky", bus.timeout, 1);
        repeat (4) drive_seg(3, 3);
        idle(4);
        check_run("post_to");
        chk("to.clear_cyc", to_clr_cyc, seg_rise[1] + SYNC + 1);
        @(negedge clk);
        bus.en = 1'b0;
        idle(2);

        // Period equal to TIMEOUT: rise beats timeout; then en drops mid-period
        start_run();
        to_set_cyc = -1;
        repeat (5) drive_seg(50, 50);
        drive_seg(30, 0);
        check_run("tmo_edge");
        chk("tmo_edge.never_to", to_set_cyc, -1);
        chk("tmo_edge.locked_before", bus.locked, 1);
        @(negedge clk);
        bus.en = 1'b0;
        nv = vlog.size();
        idle(6);
        chk("midoff.locked", bus.locked, 0);
        chk("midoff.period", bus.period, TMO);
        chk("midoff.novalid", vlog.size(), nv);
        chk("midoff.timeout", bus.timeout, 0);

        for (int r = 0; r < 6; r++) begin
            start_run();
            bh = $urandom_range(1, 5);
            bl = $urandom_range(1, 5);
            nseg = $urandom_range(6, 12);
            for (int k = 0; k < nseg; k++) begin
                if ($urandom_range(0, 3) != 0) begin
                    h = bh;
                    l = bl;
                end else begin
                    h = $urandom_range(1, 6);
                    l = $urandom_range(1, 6);
                end
                drive_seg(h, l);
            end
            end_run($sformatf("rand%0d", r));
        end

        // Asynchronous reset mid-measurement, then clk/3
        start_run();
        repeat (4) drive_seg(2, 2);
        drive_seg(2, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst.period", bus.period, 0);
        chk("arst.high", bus.high_time, 0);
        chk("arst.valid", bus.valid, 0);
        chk("arst.locked", bus.locked, 0);
        chk("arst.timeout", bus.timeout, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_run();
        repeat (5) drive_seg(2, 1);
        end_run("div3");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
